// File: rtl/apb_pkg.sv
// Shared APB definitions: one-hot sequencing states, PPROT bit positions and
// the strobe fill value used for reads. The existing APB slave uses it as well.
package apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_SETUP  = 3'b010,
      ST_ACCESS = 3'b100
   } apb_state_e;

   localparam int PPROT_PRIV_BIT   = 0;
   localparam int PPROT_NONSEC_BIT = 1;
   localparam int PPROT_INSTR_BIT  = 2;

   // APB4 requires PSTRB to be driven low for every byte lane during reads
   localparam logic APB_READ_STRB_BIT = 1'b0;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles spent with PREADY low. It flags the final permitted cycle;
// a TIMEOUT_CYCLES value of 0 disables the flag.
module apb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count == TERMINAL);

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: converts a valid/ready command into a SETUP/ACCESS transfer
// and returns a single-entry response, aborting slaves that stall for too long.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int          DATA_WIDTH     = 32,
   parameter int          ADDR_WIDTH     = 32,
   parameter int          STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   output logic [2:0]            PPROT,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   apb_state_e state, state_next;

   logic accept;
   logic complete;
   logic expired;
   logic abort;

   assign cmd_ready = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign complete  = (state == ST_ACCESS) && PREADY;
   // PREADY on the terminal cycle takes priority over the timeout
   assign abort     = (state == ST_ACCESS) && !PREADY && expired;

   apb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_timeout (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (state == ST_SETUP),
      .enable  ((state == ST_ACCESS) && !PREADY),
      .expired (expired)
   );

   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_IDLE:   state_next = accept ? ST_SETUP : ST_IDLE;
         ST_SETUP:  state_next = ST_ACCESS;
         ST_ACCESS: state_next = (complete || abort) ? ST_IDLE : ST_ACCESS;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state       <= ST_IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         PPROT       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state <= state_next;
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  PADDR   <= cmd_addr;
                  PWRITE  <= cmd_write;
                  PWDATA  <= cmd_wdata;
                  PPROT   <= cmd_prot;
                  PSTRB   <= cmd_write ? cmd_strb : {STRB_WIDTH{APB_READ_STRB_BIT}};
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
            end
            ST_ACCESS: begin
               if (complete || abort) begin
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= (complete && !PWRITE) ? PRDATA : '0;
                  rsp_err     <= abort ? 1'b1 : PSLVERR;
                  rsp_timeout <= abort;
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB4 requester that turns a simple valid/ready command interface into APB4 transfers toward register-bank slaves such as the DMA configuration block. It sequences SETUP/ACCESS phases, honours slave wait states via PREADY, captures PRDATA/PSLVERR, and returns a single-entry response with timeout protection. It sits between the system-side control master (CPU bridge or test sequencer) and the APB fabric.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA/cmd data width
ADDR_WIDTH, 32, PADDR/cmd address width
STRB_WIDTH, DATA_WIDTH/8, byte strobe width
TIMEOUT_CYCLES, 256, max ACCESS cycles with PREADY low before abort; 0 disables timeout
CNT_WIDTH, 16, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  STRB_WIDTH  write byte strobes
cmd_prot  in  3  PPROT value
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  STRB_WIDTH  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset (PRESETn low at PCLK edge): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, counter all 0. Reset mid-transfer aborts immediately; no response generated.
- States one-hot: IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100; illegal encoding -> IDLE.
- cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready); combinational.
- IDLE: on cmd accept, register PADDR/PWRITE/PWDATA/PPROT; PSTRB=cmd_strb for writes, all-zero for reads (APB4 rule); PSEL<=1, PENABLE<=0; -> SETUP.
- SETUP: exactly one cycle; PENABLE<=1; counter<=0; -> ACCESS.
- ACCESS: PADDR/PWRITE/PWDATA/PSTRB/PPROT held stable. If PREADY=1: PSEL<=0, PENABLE<=0; rsp_valid<=1, rsp_rdata<=PWRITE?0:PRDATA, rsp_err<=PSLVERR, rsp_timeout<=0; -> IDLE. Else counter++.
- Timeout: TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with PREADY=0 -> PSEL<=0, PENABLE<=0, rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0; -> IDLE. PREADY=1 on that same cycle wins (normal completion).
- Minimum latency: cmd accept at cycle N, PSEL high N+1, PENABLE high N+2, rsp_valid high N+3 with zero wait states.
- rsp_valid cleared on rsp_ready unless a new completion sets it same cycle (set wins; new data loaded). Response fields stable while rsp_valid && !rsp_ready.
- Back-to-back: cmd accepted in IDLE same cycle previous rsp consumed; PSEL drops for one cycle between transfers (no ACCESS->SETUP chaining).
- APB outputs other than PSEL/PENABLE keep last value after completion (no toggling when idle).

Decomposition:
- Shared package apb_pkg: state localparams (IDLE/SETUP/ACCESS one-hot), PPROT bit positions, default strobe constant; reused by the existing slave.
- One sub-module natural: apb_timeout_counter (enable, clear, terminal-count compare, disable on 0).

Test Plan:
- Write, no wait: cmd write addr 0x10 data 0xDEADBEEF strb 0xF -> PSEL at N+1, PENABLE at N+2, PSTRB=0xF, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x80, PREADY low 3 cycles, PRDATA=0x12345678 -> rsp_rdata=0x12345678 at N+6, PSTRB=0 throughout, address stable all ACCESS cycles.
- Slave error: write addr 0x8C, PSLVERR=1 with PREADY -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL/PENABLE drop after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1; PREADY=1 on 4th cycle -> normal completion.
- Backpressure/back-to-back: rsp_ready low 5 cycles -> cmd_ready low, response stable; rsp_ready high with cmd_valid -> next transfer accepted same cycle, PSEL low exactly one cycle.
- Reset mid-ACCESS: PRESETn low during wait state -> next edge all outputs 0, state IDLE, no rsp_valid.
